// File: rtl/bk_pipe_adder.sv
// -----------------------------------------------------------------------------
// bk_pipe_adder
//
// Three-stage pipelined adder/subtractor whose carries come from a Brent-Kung
// parallel-prefix network. One beat per cycle is accepted through a
// valid/ready handshake. A downstream stall freezes all three stages together.
//
// Parameters
//   WIDTH      operand/sum width, a power of two in 4..128 (default 32)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat offered
//   in_ready   beat can be taken this cycle (!out_valid || out_ready)
//   A, B       operands
//   Cin        carry-in, ignored when Sub=1
//   Sub        0: S = A + B + Cin, 1: S = A - B (A + ~B + 1)
//   out_valid  result beat present on S/Cout
//   out_ready  consumer takes the result this cycle
//   S          sum or difference, modulo 2^WIDTH
//   Cout       carry out of bit WIDTH-1 (for Sub=1, 1 means no borrow)
//   Ovf        signed overflow, aligned with S
//              (only when BK_PIPE_ADDER_OVF_EN is defined)
//
// Optional feature
//   BK_PIPE_ADDER_OVF_EN  adds the Ovf port and its pipeline bits.
//
// Stages
//   S1: bitwise generate/propagate, effective B and carry-in registered
//   S2: carry-in folded into bit 0, up-sweep of the prefix tree registered
//   S3: down-sweep completes every carry, sum XOR, S/Cout registered
// -----------------------------------------------------------------------------
module bk_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef BK_PIPE_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int LOG_W = $clog2(WIDTH);

  // Pipeline control
  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic advance;
  logic accept;

  // The whole pipeline moves only when the output slot is free or being
  // drained, so bubbles keep their positions through a stall.
  assign in_ready  = !out_valid || out_ready;
  assign advance   = in_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: bitwise generate/propagate and effective carry-in
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_p1_d, p_p1_d;
  logic             cin_p1_d;
  logic [WIDTH-1:0] g_p1_q, p_p1_q;
  logic             cin_p1_q;

  // Subtraction is A + ~B + 1, so Cin is overridden by the forced 1.
  assign b_eff    = Sub ? ~B : B;
  assign g_p1_d   = A & b_eff;
  assign p_p1_d   = A ^ b_eff;
  assign cin_p1_d = Sub | Cin;

  always_ff @(posedge clk) begin
    if (advance) begin
      g_p1_q   <= g_p1_d;
      p_p1_q   <= p_p1_d;
      cin_p1_q <= cin_p1_d;
    end
  end

`ifdef BK_PIPE_ADDER_OVF_EN
  logic amsb_p1_q, bmsb_p1_q;

  always_ff @(posedge clk) begin
    if (advance) begin
      amsb_p1_q <= A[WIDTH-1];
      bmsb_p1_q <= b_eff[WIDTH-1];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: up-sweep
  // ---------------------------------------------------------------------------
  // Level 0 folds the carry-in into bit 0's generate, so every prefix
  // generate G[i:0] produced below is directly the carry out of bit i.
  // Level l combines node i with node i-2^(l-1) wherever (i+1) is a multiple
  // of 2^l, building power-of-two aligned groups.
  for (genvar l = 0; l <= LOG_W; l++) begin : g_up
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : g_base
      assign g = {g_p1_q[WIDTH-1:1], g_p1_q[0] | (p_p1_q[0] & cin_p1_q)};
      assign p = p_p1_q;
    end else begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << l)) == 0) begin : g_node
          assign g[i] = g_up[l-1].g[i]
                      | (g_up[l-1].p[i] & g_up[l-1].g[i - (1 << (l - 1))]);
          assign p[i] = g_up[l-1].p[i] & g_up[l-1].p[i - (1 << (l - 1))];
        end else begin : g_pass
          assign g[i] = g_up[l-1].g[i];
          assign p[i] = g_up[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] gg_p2_d, pg_p2_d;
  logic [WIDTH-1:0] gg_p2_q, pg_p2_q, p_p2_q;
  logic             cin_p2_q;

  assign gg_p2_d = g_up[LOG_W].g;
  assign pg_p2_d = g_up[LOG_W].p;

  always_ff @(posedge clk) begin
    if (advance) begin
      gg_p2_q  <= gg_p2_d;
      pg_p2_q  <= pg_p2_d;
      p_p2_q   <= p_p1_q;
      cin_p2_q <= cin_p1_q;
    end
  end

`ifdef BK_PIPE_ADDER_OVF_EN
  logic amsb_p2_q, bmsb_p2_q;

  always_ff @(posedge clk) begin
    if (advance) begin
      amsb_p2_q <= amsb_p1_q;
      bmsb_p2_q <= bmsb_p1_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: down-sweep, sum XOR
  // ---------------------------------------------------------------------------
  // Down-sweep level d works on span 2^lv with lv = LOG_W - d: a node at
  // i = k*2^lv + 2^(lv-1) - 1 (k >= 1) already holds the group [i : i-2^(lv-1)+1]
  // from the up-sweep and merges it with the completed prefix just below.
  for (genvar d = 0; d < LOG_W; d++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (d == 0) begin : g_base
      assign g = gg_p2_q;
    end else begin : g_lvl
      localparam int LV = LOG_W - d;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((i >= (1 << LV)) && (((i + 1) % (1 << LV)) == (1 << (LV - 1)))) begin : g_node
          assign g[i] = g_dn[d-1].g[i]
                      | (pg_p2_q[i] & g_dn[d-1].g[i - (1 << (LV - 1))]);
        end else begin : g_pass
          assign g[i] = g_dn[d-1].g[i];
        end
      end
    end
  end

  // Group propagates of nodes that are never a down-sweep target are not
  // needed after the up-sweep; they are simply carried along.
  logic pg_unused;
  assign pg_unused = ^pg_p2_q;

  logic [WIDTH-1:0] carry_in_vec;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  assign carry_in_vec = {g_dn[LOG_W-1].g[WIDTH-2:0], cin_p2_q};
  assign s_d          = p_p2_q ^ carry_in_vec;
  assign cout_d       = g_dn[LOG_W-1].g[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (advance) begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

`ifdef BK_PIPE_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Overflow: both addends share a sign and the result sign differs.
  assign ovf_d = (amsb_p2_q == bmsb_p2_q) && (s_d[WIDTH-1] != amsb_p2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bk_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_bk_pipe_adder
//
// Drives three instances (WIDTH = 8, 32, 64) from one shared handshake and
// operand stream and compares them with a behavioural model: plain integer
// arithmetic per beat, and a three-deep delay line that moves only when the
// output slot is free or being drained. Directed vectors cover the example
// sums, stalls and reset with beats in flight; a random phase follows.
// -----------------------------------------------------------------------------
module tb_bk_pipe_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, Cin, Sub, out_ready;
  logic [63:0] A64, B64;

  always #5 clk = ~clk;

  logic        in_ready8, in_ready32, in_ready64;
  logic        out_valid8, out_valid32, out_valid64;
  logic [7:0]  S8;
  logic [31:0] S32;
  logic [63:0] S64;
  logic        Cout8, Cout32, Cout64;
`ifdef BK_PIPE_ADDER_OVF_EN
  logic        Ovf8, Ovf32, Ovf64;
`endif

  bk_pipe_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .A(A64[7:0]), .B(B64[7:0]), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid8), .out_ready(out_ready), .S(S8), .Cout(Cout8)
`ifdef BK_PIPE_ADDER_OVF_EN
    , .Ovf(Ovf8)
`endif
  );

  bk_pipe_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .A(A64[31:0]), .B(B64[31:0]), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid32), .out_ready(out_ready), .S(S32), .Cout(Cout32)
`ifdef BK_PIPE_ADDER_OVF_EN
    , .Ovf(Ovf32)
`endif
  );

  bk_pipe_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .A(A64), .B(B64), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid64), .out_ready(out_ready), .S(S64), .Cout(Cout64)
`ifdef BK_PIPE_ADDER_OVF_EN
    , .Ovf(Ovf64)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Full (w+1)-bit result of A + B + Cin or A - B, from plain arithmetic.
  function automatic logic [64:0] ref_total(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic ci,
                                            input logic sb);
    logic [64:0] mask, am, bm, c;
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    c    = {64'd0, ci};
    if (sb) return ((am + (mask + 65'd1) - bm) & ((mask << 1) | 65'd1));
    return am + bm + c;
  endfunction

  // Signed overflow: true signed result falls outside the w-bit range.
  function automatic logic ref_ovf(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic ci,
                                   input logic sb);
    logic        [67:0] ua, ub;
    logic signed [67:0] sa, sbv, sum, hi, lo;
    ua  = {4'd0, a} << (68 - w);
    ub  = {4'd0, b} << (68 - w);
    sa  = $signed(ua) >>> (68 - w);
    sbv = $signed(ub) >>> (68 - w);
    sum = sb ? (sa - sbv) : (sa + sbv + $signed({67'd0, ci}));
    hi  = (68'sd1 <<< (w - 1)) - 68'sd1;
    lo  = -(68'sd1 <<< (w - 1));
    return (sum > hi) || (sum < lo);
  endfunction

  typedef struct packed {
    logic [64:0] t8, t32, t64;
    logic        o8, o32, o64;
  } exp_t;

  exp_t md [3];
  logic mv [3];
  logic out_zero;

  // One clock of stimulus: inputs set just after a falling edge, in_ready
  // checked, model advanced at the rising edge, outputs checked at the next
  // falling edge.
  task automatic step(input logic r, input logic iv, input logic [63:0] a,
                      input logic [63:0] b, input logic ci, input logic sb,
                      input logic ordy, output logic acc);
    logic exp_ir;
    exp_t e;
    rst = r; in_valid = iv; A64 = a; B64 = b; Cin = ci; Sub = sb; out_ready = ordy;
    #1;
    exp_ir = !mv[2] || ordy;
    chk("in_ready8",  65'(in_ready8),  65'(exp_ir));
    chk("in_ready32", 65'(in_ready32), 65'(exp_ir));
    chk("in_ready64", 65'(in_ready64), 65'(exp_ir));
    acc = iv && exp_ir && !r;
    e.t8  = ref_total(8,  a, b, ci, sb);
    e.t32 = ref_total(32, a, b, ci, sb);
    e.t64 = ref_total(64, a, b, ci, sb);
    e.o8  = ref_ovf(8,  a, b, ci, sb);
    e.o32 = ref_ovf(32, a, b, ci, sb);
    e.o64 = ref_ovf(64, a, b, ci, sb);
    @(posedge clk);
    if (r) begin
      mv[0] = 1'b0; mv[1] = 1'b0; mv[2] = 1'b0;
      out_zero = 1'b1;
    end else if (exp_ir) begin
      mv[2] = mv[1]; md[2] = md[1];
      mv[1] = mv[0]; md[1] = md[0];
      mv[0] = acc;   md[0] = e;
      out_zero = 1'b0;
    end
    @(negedge clk);
    chk("out_valid8",  65'(out_valid8),  65'(mv[2]));
    chk("out_valid32", 65'(out_valid32), 65'(mv[2]));
    chk("out_valid64", 65'(out_valid64), 65'(mv[2]));
    if (mv[2]) begin
      chk("s8",     65'(S8),     65'(md[2].t8[7:0]));
      chk("cout8",  65'(Cout8),  65'(md[2].t8[8]));
      chk("s32",    65'(S32),    65'(md[2].t32[31:0]));
      chk("cout32", 65'(Cout32), 65'(md[2].t32[32]));
      chk("s64",    65'(S64),    65'(md[2].t64[63:0]));
      chk("cout64", 65'(Cout64), 65'(md[2].t64[64]));
`ifdef BK_PIPE_ADDER_OVF_EN
      chk("ovf8",  65'(Ovf8),  65'(md[2].o8));
      chk("ovf32", 65'(Ovf32), 65'(md[2].o32));
      chk("ovf64", 65'(Ovf64), 65'(md[2].o64));
`endif
    end else if (out_zero) begin
      chk("rst_s8",     65'(S8),     65'd0);
      chk("rst_s32",    65'(S32),    65'd0);
      chk("rst_s64",    65'(S64),    65'd0);
      chk("rst_cout32", 65'(Cout32), 65'd0);
      chk("rst_cout64", 65'(Cout64), 65'd0);
`ifdef BK_PIPE_ADDER_OVF_EN
      chk("rst_ovf32", 65'(Ovf32), 65'd0);
`endif
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'h8000_0000_0000_0080;
      3:       return 64'h7FFF_FFFF_FFFF_FF7F;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic        acc;
    int          idx;
    logic [63:0] ba [10];
    logic [63:0] bb [10];
    logic        bc [10];
    logic        bs [10];

    mv[0] = 1'b0; mv[1] = 1'b0; mv[2] = 1'b0;
    out_zero = 1'b0;
    rst = 1'b1; in_valid = 1'b0; A64 = '0; B64 = '0; Cin = 1'b0; Sub = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset state, with a beat offered that must not be taken.
    step(1'b1, 1'b1, 64'd3, 64'd4, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);

    // FFFF0000 + 0000FFFF + 1 wraps to zero with carry out.
    step(1'b0, 1'b1, 64'hFFFF0000, 64'h0000FFFF, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("lat_not_yet", 65'(out_valid32), 65'd0);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("wrap_valid", 65'(out_valid32), 65'd1);
    chk("wrap_s",     65'(S32),         65'h0000_0000);
    chk("wrap_cout",  65'(Cout32),      65'd1);

    // Back-to-back beats retire on consecutive cycles.
    step(1'b0, 1'b1, 64'd2017701177, 64'd1701853, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 64'hFFABCEDC, 64'hEF821EDA, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("b2b_s1",    65'(S32),    65'd2019403030);
    chk("b2b_cout1", 65'(Cout32), 65'd0);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("b2b_s2",    65'(S32),    65'hEF2DEDB7);
    chk("b2b_cout2", 65'(Cout32), 65'd1);

    // Subtraction with borrow; Cin=1 must be ignored.
    step(1'b0, 1'b1, 64'd5, 64'd7, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, 1'b1, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("sub_s",    65'(S32),    65'hFFFF_FFFE);
    chk("sub_cout", 65'(Cout32), 65'd0);
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    chk("ovf_s", 65'(S32), 65'h8000_0000);
`ifdef BK_PIPE_ADDER_OVF_EN
    chk("ovf_flag", 65'(Ovf32), 65'd1);
`endif

    // Ten random beats with a four-cycle consumer stall mid-stream.
    for (int i = 0; i < 10; i++) begin
      ba[i] = pick(); bb[i] = pick();
      bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 10)
        step(1'b0, 1'b1, ba[idx], bb[idx], bc[idx], bs[idx], !(c >= 4 && c < 8), acc);
      else
        step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("stall_beats_taken", 65'(idx), 65'd10);

    // Reset with two beats in flight discards both.
    step(1'b0, 1'b1, 64'd100, 64'd200, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 64'd300, 64'd400, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 1'b1, 64'd500, 64'd600, 1'b0, 1'b0, 1'b1, acc);
    chk("mid_rst_valid", 65'(out_valid32), 65'd0);
    chk("mid_rst_s",     65'(S32),         65'd0);
    chk("mid_rst_cout",  65'(Cout32),      65'd0);
    // First edge with rst low must already take a beat.
    step(1'b0, 1'b1, 64'd9, 64'd8, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);

    // Random traffic with random back-pressure and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
           pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), acc);
    end
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bk_pipe_adder.md
BK_PIPE_ADDER -- requirements
Module: bk_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width; SHALL be a power of two, 4..128.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Cin  input  1  carry-in; ignored when Sub=1.
REQ-009 Sub  input  1  0: S=A+B+Cin; 1: S=A+~B+1, i.e. A-B.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 S  output  WIDTH  sum or difference.
REQ-013 Cout  output  1  carry-out of bit WIDTH-1; for Sub=1, 1 means no borrow.
REQ-014 Ovf  output  1  signed overflow; present only per REQ-030.

Function
REQ-015 Carry computation SHALL be a Brent-Kung parallel-prefix network of log2(WIDTH) up-sweep levels and log2(WIDTH)-1 down-sweep levels; no ripple chain longer than one bit.
REQ-016 Pipeline SHALL have exactly 3 register stages: S1 = registered generate/propagate and effective carry-in; S2 = after up-sweep; S3 = after down-sweep, with final sum XOR, registered S/Cout.
REQ-017 Beat accepted when in_valid && in_ready at a clock edge; accepted operands SHALL appear on S/Cout with out_valid=1 exactly 3 cycles later, absent stalls.
REQ-018 Each stage SHALL carry a valid bit; data in bubble stages is don't-care but SHALL NOT raise out_valid.
REQ-019 Stall: when out_valid=1 and out_ready=0, all three stages SHALL hold, S/Cout/out_valid SHALL stay stable, and in_ready SHALL be 0.
REQ-020 in_ready SHALL equal !out_valid || out_ready, combinationally; no other path to in_ready.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1; accepting a new beat and retiring a result in the same cycle SHALL lose nothing.
REQ-022 Bubbles SHALL NOT be compressed during a stall; the pipeline moves as a whole.
REQ-023 Results SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-024 Arithmetic is modulo 2^WIDTH; Cout is bit WIDTH of the full (WIDTH+1)-bit result.
REQ-025 Sub and Cin SHALL be sampled with A/B at acceptance and travel with the beat; mode changes between beats SHALL take effect per beat.

Reset
REQ-026 While rst=1 at a clock edge, all stage valid bits SHALL clear, and S, Cout and Ovf (if present) SHALL be 0 after that edge.
REQ-027 While rst=1, in_ready SHALL be 1 per REQ-020, but no beat SHALL be accepted.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no partial result SHALL be emitted after rst deasserts.
REQ-029 First beat after reset deassertion SHALL be acceptable on the first edge with rst=0.

Configuration
REQ-030 Macro BK_PIPE_ADDER_OVF_EN: when defined, port Ovf SHALL exist, registered in S3 and aligned with S, equal to (a_msb==b_eff_msb)&&(s_msb!=a_msb), where b_eff is ~B when Sub=1; when undefined, port Ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=32, A=FFFF0000, B=0000FFFF, Cin=1, Sub=0 -> S=00000000, Cout=1, out_valid 3 cycles after acceptance.
REQ-032 A=2017701177, B=1701853, Cin=0, then A=FFABCEDC, B=EF821EDA, Cin=1 on consecutive cycles, out_ready=1 -> S=2019403030 with Cout=0, then S=EF2DEDB7 with Cout=1, on consecutive cycles.
REQ-033 Sub=1, A=5, B=7 -> S=FFFFFFFE, Cout=0; with OVF_EN, A=7FFFFFFF, B=1, Sub=0, Cin=0 -> S=80000000, Ovf=1.
REQ-034 Stream 10 random beats with out_ready held 0 for 4 cycles mid-stream -> in_ready=0 and S stable during the stall, all 10 results correct and in order.
REQ-035 rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0, S=0, Cout=0 next cycle, and neither beat ever emitted.
REQ-036 WIDTH=8 and WIDTH=64 builds, exhaustive for 8 bits and 1000 random beats for 64 bits -> matches a behavioural reference model.
